mult_pipe_unit: RTL and testbench

//  Parametrised pipelined integer multiplier FU for the R10000-style OoO core; successor to the fixed 8-stage mult.

---
 rtl/mult_pipe_unit_pkg.sv | 44 ++++
 rtl/mult_pipe_stage.sv | 100 ++++++++++
 rtl/mult_pipe_unit.sv | 161 ++++++++++++++++
 tb/tb_mult_pipe_unit.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pipe_unit_pkg.sv
// ---------------------------------------------------------------------------
// mult_pipe_unit_pkg
//   Shared definitions for the pipelined integer multiplier functional unit.
//   Provides the default geometry of the unit, the accumulator width factor
//   selected by the optional high-half feature, and the record types that
//   describe one in-flight multiply at the default geometry.
//
//   Configuration macro: MULT_HIGH_EN
//     defined   -> accumulator is 2*XLEN wide and ops may request the upper
//                  XLEN product bits (UMULH) through in_high.
//     undefined -> accumulator is XLEN wide, low half only.
// ---------------------------------------------------------------------------
package mult_pipe_unit_pkg;

  localparam int XLEN_DEF      = 64;
  localparam int NUM_STAGE_DEF = 4;
  localparam int TAG_W_DEF     = 6;
  localparam int BR_W_DEF      = 4;

`ifdef MULT_HIGH_EN
  // The upper half needs the full double-width product.
  localparam int ACC_MULT = 2;
`else
  localparam int ACC_MULT = 1;
`endif

  typedef logic [BR_W_DEF-1:0] BR_MASK_t;

  // Contents of one pipeline stage at the default geometry. The multiplicand
  // is as wide as the accumulator because it is shifted left every stage and
  // its upper bits feed the high half.
  typedef struct packed {
    logic                           valid;
    logic [TAG_W_DEF-1:0]           tag;
    BR_MASK_t                       brmask;
    logic [ACC_MULT*XLEN_DEF-1:0]   prod;
    logic [XLEN_DEF-1:0]            mplier;
    logic [ACC_MULT*XLEN_DEF-1:0]   mcand;
`ifdef MULT_HIGH_EN
    logic                           high;
`endif
  } MULT_STAGE_t;

endpackage

// File: rtl/mult_pipe_stage.sv
// ---------------------------------------------------------------------------
// mult_pipe_stage
//   One step of the pipelined multiplier: adds the product of the lowest
//   XLEN/NUM_STAGE multiplier bits and the multiplicand into the accumulator,
//   shifts the operands for the next step and registers the result together
//   with the op's tag and branch mask. Also applies branch kill (drops the
//   valid bit) and correct-prediction clear (drops the resolved mask bit).
//
//   Configuration macro: MULT_HIGH_EN adds the prev_high/high pass-through.
//
//   Ports
//     clock, reset          clock, synchronous active-high reset
//     load                  register takes the prev_* op this cycle
//     br_valid/mispredict   branch resolution broadcast
//     br_bit                one-hot branch being resolved
//     prev_*                op arriving from the previous stage (or issue)
//     valid, tag, brmask,
//     prod, mplier, mcand   registered stage contents
// ---------------------------------------------------------------------------
module mult_pipe_stage
  import mult_pipe_unit_pkg::*;
#(
  parameter  int XLEN      = XLEN_DEF,
  parameter  int NUM_STAGE = NUM_STAGE_DEF,
  parameter  int TAG_W     = TAG_W_DEF,
  parameter  int BR_W      = BR_W_DEF,
  localparam int ACC_W     = ACC_MULT * XLEN
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             br_valid,
  input  logic             br_mispredict,
  input  logic [BR_W-1:0]  br_bit,
  input  logic             prev_valid,
  input  logic [TAG_W-1:0] prev_tag,
  input  logic [BR_W-1:0]  prev_brmask,
  input  logic [ACC_W-1:0] prev_prod,
  input  logic [XLEN-1:0]  prev_mplier,
  input  logic [ACC_W-1:0] prev_mcand,
`ifdef MULT_HIGH_EN
  input  logic             prev_high,
  output logic             high,
`endif
  output logic             valid,
  output logic [TAG_W-1:0] tag,
  output logic [BR_W-1:0]  brmask,
  output logic [ACC_W-1:0] prod,
  output logic [XLEN-1:0]  mplier,
  output logic [ACC_W-1:0] mcand
);

  localparam int CHUNK = XLEN / NUM_STAGE;

  logic [CHUNK-1:0] digit;
  logic [ACC_W-1:0] partial;
  logic [ACC_W-1:0] prod_next;
  logic [BR_W-1:0]  clear_mask;
  logic             prev_kill;
  logic             self_kill;

  // Truncation to ACC_W gives the modulo-2^ACC_W arithmetic directly.
  assign digit     = prev_mplier[CHUNK-1:0];
  assign partial   = prev_mcand * ACC_W'(digit);
  assign prod_next = prev_prod + partial;

  assign clear_mask = (br_valid && !br_mispredict) ? br_bit : '0;
  assign prev_kill  = br_valid && br_mispredict && |(prev_brmask & br_bit);
  assign self_kill  = br_valid && br_mispredict && |(brmask & br_bit);

  // NOTE: state is updated with non-blocking assignments so every stage
  // samples its neighbour's pre-edge value regardless of block ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= prev_valid && !prev_kill;
    end else begin
      valid <= valid && !self_kill;
    end
  end

  // NOTE: only valid is reset; the payload is meaningless while valid is low,
  // so it is left unreset and simply overwritten on the next load.
  always_ff @(posedge clock) begin
    if (load) begin
      tag    <= prev_tag;
      brmask <= prev_brmask & ~clear_mask;
      prod   <= prod_next;
      mplier <= prev_mplier >> CHUNK;
      mcand  <= prev_mcand << CHUNK;
`ifdef MULT_HIGH_EN
      high   <= prev_high;
`endif
    end else begin
      brmask <= brmask & ~clear_mask;
    end
  end

endmodule

// File: rtl/mult_pipe_unit.sv
// ---------------------------------------------------------------------------
// mult_pipe_unit
//   Pipelined unsigned integer multiplier FU. Accepts one op per cycle from
//   issue (valid/ready), walks it through NUM_STAGE partial-product stages and
//   presents the product to CDB arbitration tagged with its destination PR.
//   Speculative ops are squashed in flight on mispredict and have their
//   branch masks trimmed on correct resolution.
//
//   Configuration macro: MULT_HIGH_EN
//     defined   -> extra input in_high; in_high=1 returns the upper XLEN
//                  product bits, 0 the lower XLEN bits.
//     undefined -> no in_high port; low half only.
//
//   Parameters: XLEN (operand width), NUM_STAGE (1,2,4,8,16, divides XLEN),
//               TAG_W (PR index width), BR_W (branch mask width).
//
//   Ports
//     clock, reset        clock, synchronous active-high reset
//     in_valid/in_ready   issue handshake
//     in_a, in_b          multiplier, multiplicand
//     in_tag, in_brmask   destination PR, branch dependencies
//     br_valid            branch resolved this cycle
//     br_mispredict       1 = squash dependants, 0 = prediction correct
//     br_bit              one-hot branch being resolved
//     out_valid/out_ready CDB handshake
//     out_result          product
//     out_tag, out_brmask destination PR, remaining dependencies
//     busy                any stage holds an op
// ---------------------------------------------------------------------------
module mult_pipe_unit
  import mult_pipe_unit_pkg::*;
#(
  parameter  int XLEN      = XLEN_DEF,
  parameter  int NUM_STAGE = NUM_STAGE_DEF,
  parameter  int TAG_W     = TAG_W_DEF,
  parameter  int BR_W      = BR_W_DEF,
  localparam int ACC_W     = ACC_MULT * XLEN
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [BR_W-1:0]  in_brmask,
`ifdef MULT_HIGH_EN
  input  logic             in_high,
`endif
  input  logic             br_valid,
  input  logic             br_mispredict,
  input  logic [BR_W-1:0]  br_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic [BR_W-1:0]  out_brmask,
  output logic             busy
);

  // Chain index 0 is the incoming op; index k+1 is the register of stage k.
  logic             ch_valid  [NUM_STAGE+1];
  logic [TAG_W-1:0] ch_tag    [NUM_STAGE+1];
  logic [BR_W-1:0]  ch_brmask [NUM_STAGE+1];
  logic [ACC_W-1:0] ch_prod   [NUM_STAGE+1];
  logic [XLEN-1:0]  ch_mplier [NUM_STAGE+1];
  logic [ACC_W-1:0] ch_mcand  [NUM_STAGE+1];
`ifdef MULT_HIGH_EN
  logic             ch_high   [NUM_STAGE+1];
`endif

  logic [NUM_STAGE-1:0] stage_valid;
  logic [NUM_STAGE-1:0] stage_adv;
  logic [NUM_STAGE-1:0] stage_accept;
  logic                 last_kill;
  logic                 last_adv;
  logic                 unused_tail;

  assign ch_valid[0]  = in_valid;
  assign ch_tag[0]    = in_tag;
  assign ch_brmask[0] = in_brmask;
  assign ch_prod[0]   = '0;
  assign ch_mplier[0] = in_a;
  assign ch_mcand[0]  = ACC_W'(in_b);
`ifdef MULT_HIGH_EN
  assign ch_high[0]   = in_high;
`endif

  for (genvar k = 0; k < NUM_STAGE; k++) begin : g_stage
    mult_pipe_stage #(
      .XLEN      (XLEN),
      .NUM_STAGE (NUM_STAGE),
      .TAG_W     (TAG_W),
      .BR_W      (BR_W)
    ) u_stage (
      .clock         (clock),
      .reset         (reset),
      .load          (stage_accept[k]),
      .br_valid      (br_valid),
      .br_mispredict (br_mispredict),
      .br_bit        (br_bit),
      .prev_valid    (ch_valid[k]),
      .prev_tag      (ch_tag[k]),
      .prev_brmask   (ch_brmask[k]),
      .prev_prod     (ch_prod[k]),
      .prev_mplier   (ch_mplier[k]),
      .prev_mcand    (ch_mcand[k]),
`ifdef MULT_HIGH_EN
      .prev_high     (ch_high[k]),
      .high          (ch_high[k+1]),
`endif
      .valid         (ch_valid[k+1]),
      .tag           (ch_tag[k+1]),
      .brmask        (ch_brmask[k+1]),
      .prod          (ch_prod[k+1]),
      .mplier        (ch_mplier[k+1]),
      .mcand         (ch_mcand[k+1])
    );
    assign stage_valid[k] = ch_valid[k+1];
  end

  // A squashed result is never offered, so the last stage treats it as empty
  // and lets it be overwritten.
  assign last_kill = br_valid && br_mispredict &&
                     |(ch_brmask[NUM_STAGE] & br_bit);
  assign out_valid = ch_valid[NUM_STAGE] && !last_kill;
  assign last_adv  = out_ready || !out_valid;

  // Stage k advances iff some stage downstream of it is empty or the output
  // drains; this is the unrolled form of "next stage empty or advancing" and
  // avoids a combinational signal that depends on its own bits.
  // NOTE: stage_adv is given a default before the loop so every bit is
  // assigned on every pass and no latch is inferred.
  always_comb begin
    logic gap;
    stage_adv = '0;
    gap       = last_adv;
    for (int k = NUM_STAGE - 1; k >= 0; k--) begin
      stage_adv[k] = gap;
      gap          = gap || !stage_valid[k];
    end
  end

  assign stage_accept = ~stage_valid | stage_adv;
  assign in_ready     = stage_accept[0];
  assign busy         = |stage_valid;

  assign out_tag    = ch_tag[NUM_STAGE];
  assign out_brmask = ch_brmask[NUM_STAGE] & ~(br_valid ? br_bit : '0);

`ifdef MULT_HIGH_EN
  assign out_result = ch_high[NUM_STAGE] ? ch_prod[NUM_STAGE][ACC_W-1:XLEN]
                                         : ch_prod[NUM_STAGE][XLEN-1:0];
`else
  assign out_result = ch_prod[NUM_STAGE];
`endif

  // The final stage's shifted operands are fully consumed.
  assign unused_tail = ^{ch_mplier[NUM_STAGE], ch_mcand[NUM_STAGE]};

endmodule

// File: tb/tb_mult_pipe_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_pipe_unit
//   Directed self-checking bench for mult_pipe_unit (default geometry:
//   XLEN=64, NUM_STAGE=4, TAG_W=6, BR_W=4). Inputs change 1 ns after the
//   rising edge; outputs are compared 1 ns later, mid-cycle.
//   Honours MULT_HIGH_EN for the in_high port and the UMULH vector.
// ---------------------------------------------------------------------------
module tb_mult_pipe_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic [5:0]  in_tag;
  logic [3:0]  in_brmask;
`ifdef MULT_HIGH_EN
  logic        in_high;
`endif
  logic        br_valid;
  logic        br_mispredict;
  logic [3:0]  br_bit;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic [5:0]  out_tag;
  logic [3:0]  out_brmask;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  mult_pipe_unit dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_a          (in_a),
    .in_b          (in_b),
    .in_tag        (in_tag),
    .in_brmask     (in_brmask),
`ifdef MULT_HIGH_EN
    .in_high       (in_high),
`endif
    .br_valid      (br_valid),
    .br_mispredict (br_mispredict),
    .br_bit        (br_bit),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_tag       (out_tag),
    .out_brmask    (out_brmask),
    .busy          (busy)
  );

  task automatic check(input string name, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    in_valid      = 1'b0;
    br_valid      = 1'b0;
    br_mispredict = 1'b0;
    br_bit        = 4'b0000;
  endtask

  task automatic drive_op(input logic [63:0] a, input logic [63:0] b,
                          input logic [5:0] tag, input logic [3:0] mask);
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_tag    = tag;
    in_brmask = mask;
  endtask

  // Hard stop if the directed sequence somehow stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          idx;
    int          got;
    logic [63:0] exp_v;

    reset     = 1'b1;
    out_ready = 1'b1;
    in_a      = '0;
    in_b      = '0;
    in_tag    = '0;
    in_brmask = '0;
`ifdef MULT_HIGH_EN
    in_high   = 1'b0;
`endif
    idle();
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_busy",      64'(busy),      64'd0);
    check("reset_in_ready",  64'(in_ready),  64'd1);

    // 1: single op, 4-cycle latency.
    drive_op(64'd3, 64'd5, 6'd7, 4'b0000);
    #1;
    check("t1_in_ready", 64'(in_ready), 64'd1);
    tick();
    idle();
    tick();
    tick();
    #1;
    check("t1_early_valid", 64'(out_valid), 64'd0);
    tick();
    #1;
    check("t1_out_valid", 64'(out_valid),  64'd1);
    check("t1_result",    out_result,      64'd15);
    check("t1_tag",       64'(out_tag),    64'd7);
    check("t1_brmask",    64'(out_brmask), 64'd0);
    tick();
    #1;
    check("t1_drained",   64'(out_valid), 64'd0);
    check("t1_idle_busy", 64'(busy),      64'd0);

    // 2: eight back-to-back ops a=i, b=all ones -> -i mod 2^64, no bubbles.
    for (int c = 0; c < 12; c++) begin
      if (c < 8) drive_op(64'(c + 1), '1, 6'(c + 1), 4'b0000);
      else       idle();
      #1;
      if (c < 8) check("t2_in_ready", 64'(in_ready), 64'd1);
      if (c >= 4) begin
        exp_v = 64'd0 - 64'(c - 3);
        check("t2_out_valid", 64'(out_valid), 64'd1);
        check("t2_result",    out_result,     exp_v);
        check("t2_tag",       64'(out_tag),   64'(c - 3));
      end
      tick();
    end
    #1;
    check("t2_drained", 64'(out_valid), 64'd0);

    // 3: back-pressure. Six ops offered while CDB stalls: four held.
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 7; c++) begin
      if (idx < 6) drive_op(64'(10 + idx), 64'd3, 6'(idx), 4'b0000);
      #1;
      if (in_ready) idx++;
      tick();
    end
    #1;
    check("t3_accepted",    64'(idx),       64'd4);
    check("t3_in_ready",    64'(in_ready),  64'd0);
    check("t3_held_valid",  64'(out_valid), 64'd1);
    check("t3_held_result", out_result,     64'd30);
    check("t3_held_tag",    64'(out_tag),   64'd0);
    check("t3_busy",        64'(busy),      64'd1);
    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 15; c++) begin
      if (idx < 6) drive_op(64'(10 + idx), 64'd3, 6'(idx), 4'b0000);
      else         idle();
      #1;
      if (out_valid) begin
        check("t3_result", out_result,   64'(3 * (10 + got)));
        check("t3_tag",    64'(out_tag), 64'(got));
        got++;
      end
      if (in_valid && in_ready) idx++;
      tick();
    end
    #1;
    check("t3_drain_count", 64'(got),  64'd6);
    check("t3_drain_busy",  64'(busy), 64'd0);

    // 4: mispredict on bit 1 kills ops in stages 1 and 3 plus the incoming op.
    drive_op(64'd2, 64'd3, 6'd1, 4'b0010);   // A
    tick();
    drive_op(64'd7, 64'd9, 6'd2, 4'b0001);   // B survives
    tick();
    drive_op(64'd5, 64'd5, 6'd3, 4'b0010);   // C
    tick();
    idle();
    tick();
    drive_op(64'd11, 64'd11, 6'd4, 4'b0010); // E, enters dead
    br_valid      = 1'b1;
    br_mispredict = 1'b1;
    br_bit        = 4'b0010;
    #1;
    check("t4_kill_out_valid", 64'(out_valid), 64'd0);
    check("t4_kill_in_ready",  64'(in_ready),  64'd1);
    check("t4_kill_busy",      64'(busy),      64'd1);
    tick();
    idle();
    #1;
    check("t4_surv_valid",  64'(out_valid),  64'd1);
    check("t4_surv_result", out_result,      64'd63);
    check("t4_surv_tag",    64'(out_tag),    64'd2);
    check("t4_surv_brmask", 64'(out_brmask), 64'b0001);
    tick();
    #1;
    check("t4_after_valid", 64'(out_valid), 64'd0);
    check("t4_after_busy",  64'(busy),      64'd0);

    // 5: correct resolve of bit 0 while the output op carries 4'b0011.
    drive_op(64'd4, 64'd4, 6'd5, 4'b0011);   // F
    tick();
    drive_op(64'd6, 64'd7, 6'd6, 4'b0001);   // G
    tick();
    idle();
    tick();
    tick();
    br_valid      = 1'b1;
    br_mispredict = 1'b0;
    br_bit        = 4'b0001;
    #1;
    check("t5_out_valid", 64'(out_valid),  64'd1);
    check("t5_result",    out_result,      64'd16);
    check("t5_tag",       64'(out_tag),    64'd5);
    check("t5_brmask",    64'(out_brmask), 64'b0010);
    tick();
    idle();
    #1;
    check("t5_next_valid",  64'(out_valid),  64'd1);
    check("t5_next_result", out_result,      64'd42);
    check("t5_next_brmask", 64'(out_brmask), 64'b0000);
    tick();
    #1;
    check("t5_drained", 64'(out_valid), 64'd0);

    // 6: 2^63 * 2^63, high then low half.
    drive_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 6'd8, 4'b0000);
`ifdef MULT_HIGH_EN
    in_high = 1'b1;
`endif
    tick();
    drive_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 6'd9, 4'b0000);
`ifdef MULT_HIGH_EN
    in_high = 1'b0;
`endif
    tick();
    idle();
    tick();
    tick();
    #1;
`ifdef MULT_HIGH_EN
    exp_v = 64'h4000_0000_0000_0000;
`else
    exp_v = 64'h0;
`endif
    check("t6_first_valid",  64'(out_valid), 64'd1);
    check("t6_first_result", out_result,     exp_v);
    check("t6_first_tag",    64'(out_tag),   64'd8);
    tick();
    #1;
    check("t6_low_valid",  64'(out_valid), 64'd1);
    check("t6_low_result", out_result,     64'd0);
    check("t6_low_tag",    64'(out_tag),   64'd9);
    tick();

    // Reset mid-stream drops everything in flight.
    drive_op(64'd2, 64'd2, 6'd11, 4'b0000);
    tick();
    drive_op(64'd3, 64'd3, 6'd12, 4'b0000);
    tick();
    idle();
    reset = 1'b1;
    #1;
    check("t6_pre_reset_busy", 64'(busy), 64'd1);
    tick();
    reset = 1'b0;
    #1;
    check("t6_reset_busy",      64'(busy),      64'd0);
    check("t6_reset_out_valid", 64'(out_valid), 64'd0);
    check("t6_reset_in_ready",  64'(in_ready),  64'd1);
    for (int c = 0; c < 4; c++) begin
      tick();
      #1;
      check("t6_no_ghost", 64'(out_valid), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
